// File: rtl/e203_fpu_pkg.sv
// Shared FPU definitions: class-mask bit positions, format encodings and
// per-format field widths used by the FCLASS path.
package e203_fpu_pkg;

  localparam int unsigned FCLS_W = 10;

  localparam int unsigned FCLS_NINF  = 0;
  localparam int unsigned FCLS_NNORM = 1;
  localparam int unsigned FCLS_NSUB  = 2;
  localparam int unsigned FCLS_NZERO = 3;
  localparam int unsigned FCLS_PZERO = 4;
  localparam int unsigned FCLS_PSUB  = 5;
  localparam int unsigned FCLS_PNORM = 6;
  localparam int unsigned FCLS_PINF  = 7;
  localparam int unsigned FCLS_SNAN  = 8;
  localparam int unsigned FCLS_QNAN  = 9;

  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  localparam int unsigned S_EXP_W = 8;
  localparam int unsigned S_MAN_W = 23;
  localparam int unsigned D_EXP_W = 11;
  localparam int unsigned D_MAN_W = 52;

  typedef logic [FCLS_W-1:0] fcls_mask_t;

endpackage

// File: rtl/e203_exu_fpu_fclass_pipe_if.sv
// FCLASS request/result channel between misc dispatch and write-back arbiter.
//   master : dispatch/arbiter side (drives request, flush, result ready)
//   slave  : FCLASS pipe (drives request ready and the result)
interface e203_exu_fpu_fclass_pipe_if #(
  parameter int unsigned FLEN   = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITAG_W = 4
);
  logic              fclass_i_valid;
  logic              fclass_i_ready;
  logic [FLEN-1:0]   fclass_i_rs1;
  logic              fclass_i_fmt;
  logic [ITAG_W-1:0] fclass_i_itag;
  logic              fclass_flush;
  logic              fclass_o_valid;
  logic              fclass_o_ready;
  logic [XLEN-1:0]   fclass_o_wbck_wdat;
  logic [ITAG_W-1:0] fclass_o_itag;

  modport master (
    output fclass_i_valid, fclass_i_rs1, fclass_i_fmt, fclass_i_itag,
           fclass_flush, fclass_o_ready,
    input  fclass_i_ready, fclass_o_valid, fclass_o_wbck_wdat, fclass_o_itag
  );

  modport slave (
    input  fclass_i_valid, fclass_i_rs1, fclass_i_fmt, fclass_i_itag,
           fclass_flush, fclass_o_ready,
    output fclass_i_ready, fclass_o_valid, fclass_o_wbck_wdat, fclass_o_itag
  );
endinterface

// File: rtl/e203_exu_fpu_fclass_core.sv
// Combinational FCLASS: (rs1, fmt) -> one-hot 10-bit RISC-V class mask.
//   rs1    : operand (FLEN bits)
//   fmt    : 0 single, 1 double (ignored when FLEN=32)
//   mask_c : class mask, exactly one bit set
module e203_exu_fpu_fclass_core
  import e203_fpu_pkg::*;
#(
  parameter int unsigned FLEN = 32
) (
  input  logic [FLEN-1:0] rs1,
  input  logic            fmt,
  output fcls_mask_t      mask_c
);

  localparam int unsigned OP_W = 64;

  logic [OP_W-1:0] op;
  logic            is_d;
  logic            unboxed;
  logic            sign;
  logic            exp_ones;
  logic            exp_zero;
  logic            man_zero;
  logic            quiet;

  // Widen to 64 so both formats index the same vector for any FLEN.
  assign op   = OP_W'(rs1);
  assign is_d = (FLEN == 64) && (fmt == FMT_D);

  // A single in a 64-bit register must be NaN-boxed, else it reads as canonical qNaN.
  assign unboxed = (FLEN == 64) && (fmt == FMT_S) && (op[63:32] != 32'hFFFF_FFFF);

  // Field decode for the selected format.
  always_comb begin
    sign     = op[S_EXP_W + S_MAN_W];
    exp_ones = &op[S_MAN_W +: S_EXP_W];
    exp_zero = ~|op[S_MAN_W +: S_EXP_W];
    man_zero = ~|op[S_MAN_W-1:0];
    quiet    = op[S_MAN_W-1];
    if (is_d) begin
      sign     = op[D_EXP_W + D_MAN_W];
      exp_ones = &op[D_MAN_W +: D_EXP_W];
      exp_zero = ~|op[D_MAN_W +: D_EXP_W];
      man_zero = ~|op[D_MAN_W-1:0];
      quiet    = op[D_MAN_W-1];
    end
  end

  // Class selection.
  always_comb begin
    mask_c = '0;
    if (unboxed) begin
      mask_c[FCLS_QNAN] = 1'b1;
    end else if (exp_ones) begin
      if (man_zero)   mask_c[sign ? FCLS_NINF : FCLS_PINF] = 1'b1;
      else if (quiet) mask_c[FCLS_QNAN] = 1'b1;
      else            mask_c[FCLS_SNAN] = 1'b1;
    end else if (exp_zero) begin
      if (man_zero) mask_c[sign ? FCLS_NZERO : FCLS_PZERO] = 1'b1;
      else          mask_c[sign ? FCLS_NSUB  : FCLS_PSUB]  = 1'b1;
    end else begin
      mask_c[sign ? FCLS_NNORM : FCLS_PNORM] = 1'b1;
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fclass_pipe.sv
// Pipelined FCLASS unit: classify ahead of stage 1, then STAGES elastic
// valid/ready registers carrying {valid, mask, itag}; flush kills all stages.
//   clk, rst_n : clock, async active-low reset
//   bus        : request (valid/ready/rs1/fmt/itag), flush, result
//                (valid/ready/wbck_wdat/itag), slave side
module e203_exu_fpu_fclass_pipe
  import e203_fpu_pkg::*;
#(
  parameter int unsigned FLEN   = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned ITAG_W = 4
) (
  input logic clk,
  input logic rst_n,
  e203_exu_fpu_fclass_pipe_if.slave bus
);

  fcls_mask_t        cls_c;
  logic              rdy_c     [STAGES+1];
  logic              up_vld_c  [STAGES];
  fcls_mask_t        up_mask_c [STAGES];
  logic [ITAG_W-1:0] up_itag_c [STAGES];
  logic              vld_q     [STAGES];
  fcls_mask_t        mask_q    [STAGES];
  logic [ITAG_W-1:0] itag_q    [STAGES];

  e203_exu_fpu_fclass_core #(
    .FLEN (FLEN)
  ) u_core (
    .rs1    (bus.fclass_i_rs1),
    .fmt    (bus.fclass_i_fmt),
    .mask_c (cls_c)
  );

  assign rdy_c[STAGES] = bus.fclass_o_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stage can take new content when empty or when its content moves on.
    assign rdy_c[k] = ~vld_q[k] | rdy_c[k+1];

    if (k == 0) begin : g_head
      assign up_vld_c[k]  = bus.fclass_i_valid;
      assign up_mask_c[k] = cls_c;
      assign up_itag_c[k] = bus.fclass_i_itag;
    end else begin : g_body
      assign up_vld_c[k]  = vld_q[k-1];
      assign up_mask_c[k] = mask_q[k-1];
      assign up_itag_c[k] = itag_q[k-1];
    end

    // Stage register; data only captured with a valid upstream to avoid toggling on bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k]  <= 1'b0;
        mask_q[k] <= '0;
        itag_q[k] <= '0;
      end else begin
        if (bus.fclass_flush) vld_q[k] <= 1'b0;
        else if (rdy_c[k])    vld_q[k] <= up_vld_c[k];
        if (rdy_c[k] && up_vld_c[k]) begin
          mask_q[k] <= up_mask_c[k];
          itag_q[k] <= up_itag_c[k];
        end
      end
    end
  end

  assign bus.fclass_i_ready     = rdy_c[0];
  assign bus.fclass_o_valid     = vld_q[STAGES-1];
  assign bus.fclass_o_wbck_wdat = XLEN'(mask_q[STAGES-1]);
  assign bus.fclass_o_itag      = itag_q[STAGES-1];

endmodule

// File: tb/tb_e203_exu_fpu_fclass_pipe.sv
// Bench for the FCLASS pipe: a FLEN=32/STAGES=1 instance and a
// FLEN=64/STAGES=2 instance, checked against a queue-based reference model.
module tb_e203_exu_fpu_fclass_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Drive / observe, index 0 = FLEN32/STAGES1, index 1 = FLEN64/STAGES2
  logic [1:0]  iv, fmt_d, fl, ordy;
  logic [3:0]  tag_d [2];
  logic [31:0] rs1_s;
  logic [63:0] rs1_dd;
  logic [1:0]  ov, ir;
  logic [31:0] wd [2];
  logic [3:0]  ot [2];

  e203_exu_fpu_fclass_pipe_if #(.FLEN(32), .XLEN(32), .ITAG_W(4)) if0 ();
  e203_exu_fpu_fclass_pipe_if #(.FLEN(64), .XLEN(32), .ITAG_W(4)) if1 ();

  assign if0.fclass_i_valid = iv[0];
  assign if0.fclass_i_rs1   = rs1_s;
  assign if0.fclass_i_fmt   = fmt_d[0];
  assign if0.fclass_i_itag  = tag_d[0];
  assign if0.fclass_flush   = fl[0];
  assign if0.fclass_o_ready = ordy[0];
  assign ov[0] = if0.fclass_o_valid;
  assign ir[0] = if0.fclass_i_ready;
  assign wd[0] = if0.fclass_o_wbck_wdat;
  assign ot[0] = if0.fclass_o_itag;

  assign if1.fclass_i_valid = iv[1];
  assign if1.fclass_i_rs1   = rs1_dd;
  assign if1.fclass_i_fmt   = fmt_d[1];
  assign if1.fclass_i_itag  = tag_d[1];
  assign if1.fclass_flush   = fl[1];
  assign if1.fclass_o_ready = ordy[1];
  assign ov[1] = if1.fclass_o_valid;
  assign ir[1] = if1.fclass_i_ready;
  assign wd[1] = if1.fclass_o_wbck_wdat;
  assign ot[1] = if1.fclass_o_itag;

  e203_exu_fpu_fclass_pipe #(.FLEN(32), .XLEN(32), .STAGES(1), .ITAG_W(4)) u_dut32 (
    .clk (clk), .rst_n (rst_n), .bus (if0)
  );

  e203_exu_fpu_fclass_pipe #(.FLEN(64), .XLEN(32), .STAGES(2), .ITAG_W(4)) u_dut64 (
    .clk (clk), .rst_n (rst_n), .bus (if1)
  );

  // Reference model: ordered list of accepted ops with their acceptance cycle.
  typedef struct {
    logic [9:0] m;
    logic [3:0] tag;
    int         t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int stg(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // IEEE-754 classification from field values.
  function automatic logic [9:0] ref_class(input logic [63:0] v, input bit dbl, input bit flen64);
    int ew, mw;
    logic [63:0] e, m, emax;
    bit s, q;
    ew = dbl ? 11 : 8;
    mw = dbl ? 52 : 23;
    if (flen64 && !dbl && v[63:32] != 32'hFFFF_FFFF) return 10'h200;
    s    = v[ew + mw];
    emax = (64'd1 << ew) - 64'd1;
    e    = (v >> mw) & emax;
    m    = v & ((64'd1 << mw) - 64'd1);
    q    = v[mw - 1];
    if (e == emax) begin
      if (m == 64'd0) return s ? 10'h001 : 10'h080;
      return q ? 10'h200 : 10'h100;
    end
    if (e == 64'd0) begin
      if (m == 64'd0) return s ? 10'h008 : 10'h010;
      return s ? 10'h004 : 10'h020;
    end
    return s ? 10'h002 : 10'h040;
  endfunction

  // Random operand biased towards special exponents/mantissas.
  function automatic logic [63:0] rand_op(input bit dbl, input bit flen64);
    int ew, mw;
    logic [63:0] e, m, v, emax;
    ew   = dbl ? 11 : 8;
    mw   = dbl ? 52 : 23;
    emax = (64'd1 << ew) - 64'd1;
    case ($urandom_range(0, 3))
      0:       e = 64'd0;
      1:       e = emax;
      default: e = {$urandom, $urandom} & emax;
    endcase
    case ($urandom_range(0, 3))
      0:       m = 64'd0;
      1:       m = 64'd1 << (mw - 1);
      default: m = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    endcase
    v = (64'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | m;
    if (flen64 && !dbl) begin
      if ($urandom_range(0, 7) == 0) v[63:32] = $urandom;
      else                            v[63:32] = 32'hFFFF_FFFF;
    end
    return v;
  endfunction

  // One clock on instance d: drive at negedge, check against the model, update it on the edge.
  task automatic step(input int d, input bit v, input logic [63:0] r, input bit f,
                      input logic [3:0] tg, input bit flush, input bit o_rdy,
                      input bit use_exp, input logic [9:0] exp_m,
                      output bit hs_in, output bit hs_out);
    exp_t h, n;
    int sz, t_now;
    bit ev, er;
    @(negedge clk);
    iv[d] = v; fmt_d[d] = f; tag_d[d] = tg; fl[d] = flush; ordy[d] = o_rdy;
    if (d == 0) rs1_s = r[31:0]; else rs1_dd = r;
    #1;
    sz = (d == 0) ? q0.size() : q1.size();
    h = '{m: '0, tag: '0, t: 0};
    if (sz > 0) h = (d == 0) ? q0[0] : q1[0];
    ev = (sz > 0) && (cyc - h.t >= stg(d));
    er = (sz < stg(d)) || o_rdy;
    checks++;
    if (ov[d] !== ev) $display("FAIL o_valid[%0d] cyc=%0d got=%b exp=%b", d, cyc, ov[d], ev);
    else passes++;
    checks++;
    if (ir[d] !== er) $display("FAIL i_ready[%0d] cyc=%0d got=%b exp=%b", d, cyc, ir[d], er);
    else passes++;
    if (ev && ov[d] === 1'b1) begin
      checks++;
      if (wd[d] !== {22'b0, h.m}) $display("FAIL wdat[%0d] cyc=%0d got=%h exp=%h", d, cyc, wd[d], {22'b0, h.m});
      else passes++;
      checks++;
      if (ot[d] !== h.tag) $display("FAIL itag[%0d] cyc=%0d got=%0d exp=%0d", d, cyc, ot[d], h.tag);
      else passes++;
      checks++;
      if ($countones(wd[d]) != 1) $display("FAIL onehot[%0d] cyc=%0d got=%h exp=one bit", d, cyc, wd[d]);
      else passes++;
    end
    hs_in  = v && er;
    hs_out = ev && o_rdy;
    n.m    = use_exp ? exp_m : ref_class(r, f && (d == 1), d == 1);
    n.tag  = tg;
    n.t    = cyc;
    t_now  = cyc;
    @(posedge clk);
    if (d == 0) begin
      if (hs_out) void'(q0.pop_front());
      if (flush) q0.delete();
      else if (hs_in) q0.push_back(n);
    end else begin
      if (hs_out) void'(q1.pop_front());
      if (flush) q1.delete();
      else if (hs_in) q1.push_back(n);
    end
    if (t_now < 0) $display("FAIL cyc counter got=%0d exp=>=0", t_now);
  endtask

  task automatic drain(input int d);
    bit a, b;
    int sz;
    for (int i = 0; i < 8; i++) step(d, 0, 64'd0, 0, 4'd0, 0, 1, 0, 10'd0, a, b);
    sz = (d == 0) ? q0.size() : q1.size();
    checks++;
    if (sz != 0) $display("FAIL drain[%0d] got=%0d outstanding exp=0", d, sz);
    else passes++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    iv = '0; fmt_d = '0; fl = '0; ordy = '0;
    tag_d[0] = '0; tag_d[1] = '0; rs1_s = '0; rs1_dd = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0) $display("FAIL reset_o_valid[%0d] got=%b exp=0", d, ov[d]); else passes++;
      checks++;
      if (wd[d] !== 32'd0) $display("FAIL reset_wdat[%0d] got=%h exp=0", d, wd[d]); else passes++;
      checks++;
      if (ot[d] !== 4'd0) $display("FAIL reset_itag[%0d] got=%0d exp=0", d, ot[d]); else passes++;
      checks++;
      if (ir[d] !== 1'b1) $display("FAIL reset_i_ready[%0d] got=%b exp=1", d, ir[d]); else passes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single32;
    logic [31:0] vec [6];
    logic [9:0]  em  [6];
    bit a, b;
    vec = '{32'hFF80_0000, 32'h8000_0001, 32'h0000_0000, 32'h7F80_0000, 32'h7FA0_0000, 32'h7FC0_0000};
    em  = '{10'h001, 10'h004, 10'h010, 10'h080, 10'h100, 10'h200};
    for (int i = 0; i < 6; i++) step(0, 1, {32'd0, vec[i]}, 0, 4'(i), 0, 1, 1, em[i], a, b);
    drain(0);
  endtask

  task automatic test_double64;
    logic [63:0] vec [4];
    bit          fm  [4];
    logic [9:0]  em  [4];
    bit a, b;
    vec = '{64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_3F80_0000, 64'h0000_0000_3F80_0000};
    fm  = '{1'b1, 1'b1, 1'b0, 1'b0};
    em  = '{10'h002, 10'h020, 10'h040, 10'h200};
    for (int i = 0; i < 4; i++) step(1, 1, vec[i], fm[i], 4'(i), 0, 1, 1, em[i], a, b);
    drain(1);
  endtask

  task automatic test_stall;
    int nxt = 0, got = 0;
    bit dropped = 0, a, b, o_rdy;
    logic [63:0] op;
    op = rand_op(1, 1);
    for (int i = 0; i < 16; i++) begin
      o_rdy = !(i >= 3 && i <= 5);
      step(1, nxt < 4, op, 1, 4'(nxt), 0, o_rdy, 0, 10'd0, a, b);
      if (nxt < 4 && !a) dropped = 1;
      if (a) begin nxt++; op = rand_op(1, 1); end
      if (b) got++;
    end
    checks++;
    if (dropped !== 1'b1) $display("FAIL stall_ready_drop got=%b exp=1", dropped); else passes++;
    checks++;
    if (got != 4) $display("FAIL stall_delivered got=%0d exp=4", got); else passes++;
    drain(1);
  endtask

  task automatic test_flush;
    bit a, b;
    step(1, 1, 64'h3FF0_0000_0000_0000, 1, 4'd5, 0, 1, 1, 10'h040, a, b);
    step(1, 1, 64'hFFF0_0000_0000_0000, 1, 4'd6, 0, 1, 1, 10'h001, a, b);
    step(1, 1, 64'h0000_0000_0000_0000, 1, 4'd7, 1, 1, 1, 10'h010, a, b);
    checks++;
    if (!(a && b)) $display("FAIL flush_cycle_handshakes got=in%b/out%b exp=1/1", a, b); else passes++;
    step(1, 1, 64'h8000_0000_0000_0000, 1, 4'd8, 0, 1, 1, 10'h008, a, b);
    drain(1);
  endtask

  task automatic test_reset_mid;
    bit a, b;
    step(1, 1, 64'hC000_0000_0000_0000, 1, 4'd9, 0, 0, 1, 10'h002, a, b);
    step(1, 0, 64'd0, 0, 4'd0, 0, 0, 0, 10'd0, a, b);
    @(negedge clk);
    #2;
    checks++;
    if (ov[1] !== 1'b1) $display("FAIL pre_reset_o_valid got=%b exp=1", ov[1]); else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[1] !== 1'b0) $display("FAIL async_reset_o_valid got=%b exp=0", ov[1]); else passes++;
    checks++;
    if (wd[1] !== 32'd0) $display("FAIL async_reset_wdat got=%h exp=0", wd[1]); else passes++;
    checks++;
    if (ot[1] !== 4'd0) $display("FAIL async_reset_itag got=%0d exp=0", ot[1]); else passes++;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 64'd0, 0, 4'd0, 0, 1, 0, 10'd0, a, b);
  endtask

  task automatic test_back_to_back;
    bit a, b;
    int acc, got;
    for (int d = 0; d < 2; d++) begin
      acc = 0; got = 0;
      for (int i = 0; i < 16 + stg(d); i++) begin
        step(d, i < 16, rand_op(d == 1 && i[0], d == 1), d == 1 && i[0], 4'(i), 0, 1, 0, 10'd0, a, b);
        if (a) acc++;
        if (b) got++;
      end
      checks++;
      if (acc != 16) $display("FAIL b2b_accepted[%0d] got=%0d exp=16", d, acc); else passes++;
      checks++;
      if (got != 16) $display("FAIL b2b_delivered[%0d] got=%0d exp=16", d, got); else passes++;
    end
  endtask

  task automatic test_random;
    bit a, b, dbl;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        dbl = (d == 1) && ($urandom_range(0, 1) == 1);
        step(d, $urandom_range(0, 3) != 0, rand_op(dbl, d == 1), dbl, 4'($urandom),
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 0, 10'd0, a, b);
      end
      drain(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single32();
    test_double64();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
